// File: rtl/axi_lite_apb_bridge.sv
// AXI4-Lite slave to APB master bridge.
// One transfer in flight; read/write grants alternate when both pend.
module axi_lite_apb_bridge #(
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        awvalid,
  output logic        awready,
  input  logic [31:0] awaddr,
  input  logic [2:0]  awprot,
  input  logic        wvalid,
  output logic        wready,
  input  logic [31:0] wdata,
  input  logic [3:0]  wstrb,
  output logic        bvalid,
  input  logic        bready,
  output logic [1:0]  bresp,
  input  logic        arvalid,
  output logic        arready,
  input  logic [31:0] araddr,
  input  logic [2:0]  arprot,
  output logic        rvalid,
  input  logic        rready,
  output logic [31:0] rdata,
  output logic [1:0]  rresp,
  output logic [31:0] paddr,
  output logic        psel,
  output logic        penable,
  output logic [2:0]  pprot,
  output logic        pwrite,
  output logic [31:0] pwdata,
  output logic [3:0]  pstrb,
  input  logic        pready,
  input  logic [31:0] prdata,
  input  logic        pslverr
);

  localparam int unsigned CW =
    (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    ACCESS,
    WRESP,
    RRESP
  } state_t;

  state_t        state_q, state_d;
  logic          rd_next_q, rd_next_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0]   paddr_q, paddr_d;
  logic [2:0]    pprot_q, pprot_d;
  logic          pwrite_q, pwrite_d;
  logic [31:0]   pwdata_q, pwdata_d;
  logic [3:0]    pstrb_q, pstrb_d;
  logic [31:0]   rdata_q, rdata_d;
  logic          err_q, err_d;

  logic idle;
  logic wr_ok;
  logic gnt_rd;
  logic gnt_wr;
  logic timeout;

  // Grant is combinational so a request is accepted in the cycle it appears.
  always_comb begin
    idle    = (state_q == IDLE) & ~reset;
    wr_ok   = awvalid & wvalid;
    gnt_rd  = idle & arvalid & (rd_next_q | ~wr_ok);
    gnt_wr  = idle & wr_ok & ~gnt_rd;
    timeout = (TIMEOUT_CYCLES != 0) && (cnt_q == TO_LAST);
  end

  always_comb begin
    state_d   = state_q;
    rd_next_d = rd_next_q;
    cnt_d     = cnt_q;
    paddr_d   = paddr_q;
    pprot_d   = pprot_q;
    pwrite_d  = pwrite_q;
    pwdata_d  = pwdata_q;
    pstrb_d   = pstrb_q;
    rdata_d   = rdata_q;
    err_d     = err_q;
    unique case (state_q)
      IDLE: begin
        if (gnt_rd | gnt_wr) begin
          state_d   = SETUP;
          rd_next_d = gnt_wr;
          paddr_d   = gnt_wr ? awaddr : araddr;
          pprot_d   = gnt_wr ? awprot : arprot;
          pwrite_d  = gnt_wr;
          pwdata_d  = gnt_wr ? wdata : '0;
          pstrb_d   = gnt_wr ? wstrb : '0;
        end
      end
      SETUP: begin
        state_d = ACCESS;
        cnt_d   = '0;
      end
      ACCESS: begin
        if (pready | timeout) begin
          state_d = pwrite_q ? WRESP : RRESP;
          err_d   = ~pready | pslverr;
          cnt_d   = '0;
          if (!pwrite_q) rdata_d = pready ? prdata : '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      WRESP: if (bready) state_d = IDLE;
      RRESP: if (rready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= IDLE;
      rd_next_q <= 1'b1;
      cnt_q     <= '0;
      paddr_q   <= '0;
      pprot_q   <= '0;
      pwrite_q  <= 1'b0;
      pwdata_q  <= '0;
      pstrb_q   <= '0;
      rdata_q   <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      rd_next_q <= rd_next_d;
      cnt_q     <= cnt_d;
      paddr_q   <= paddr_d;
      pprot_q   <= pprot_d;
      pwrite_q  <= pwrite_d;
      pwdata_q  <= pwdata_d;
      pstrb_q   <= pstrb_d;
      rdata_q   <= rdata_d;
      err_q     <= err_d;
    end
  end

  assign awready = gnt_wr;
  assign wready  = gnt_wr;
  assign arready = gnt_rd;
  assign psel    = (state_q == SETUP) | (state_q == ACCESS);
  assign penable = (state_q == ACCESS);
  assign paddr   = paddr_q;
  assign pprot   = pprot_q;
  assign pwrite  = pwrite_q;
  assign pwdata  = pwdata_q;
  assign pstrb   = pstrb_q;
  assign bvalid  = (state_q == WRESP);
  assign rvalid  = (state_q == RRESP);
  assign bresp   = {bvalid & err_q, 1'b0};
  assign rresp   = {rvalid & err_q, 1'b0};
  assign rdata   = rdata_q;

endmodule

// File: tb/tb_axi_lite_apb_bridge.sv
// Scoreboard bench for axi_lite_apb_bridge.
// A second instance with TIMEOUT_CYCLES=8 covers the timeout path.
module tb_axi_lite_apb_bridge;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic        reset = 1'b1;
  logic        awvalid = 1'b0, wvalid = 1'b0, arvalid = 1'b0;
  logic        bready = 1'b1, rready = 1'b1;
  logic [31:0] awaddr = '0, wdata = '0, araddr = '0;
  logic [2:0]  awprot = '0, arprot = '0;
  logic [3:0]  wstrb = '0;
  logic        pready = 1'b0, pslverr = 1'b0;
  logic [31:0] prdata = '0;

  logic        awready, wready, arready, bvalid, rvalid;
  logic        psel, penable, pwrite;
  logic [1:0]  bresp, rresp;
  logic [31:0] rdata, paddr, pwdata;
  logic [2:0]  pprot;
  logic [3:0]  pstrb;

  logic        t_awready, t_wready, t_arready, t_bvalid, t_rvalid;
  logic        t_psel, t_penable, t_pwrite;
  logic [1:0]  t_bresp, t_rresp;
  logic [31:0] t_rdata, t_paddr, t_pwdata;
  logic [2:0]  t_pprot;
  logic [3:0]  t_pstrb;

  axi_lite_apb_bridge dut (
    .clock(clock), .reset(reset),
    .awvalid(awvalid), .awready(awready),
    .awaddr(awaddr), .awprot(awprot),
    .wvalid(wvalid), .wready(wready),
    .wdata(wdata), .wstrb(wstrb),
    .bvalid(bvalid), .bready(bready), .bresp(bresp),
    .arvalid(arvalid), .arready(arready),
    .araddr(araddr), .arprot(arprot),
    .rvalid(rvalid), .rready(rready),
    .rdata(rdata), .rresp(rresp),
    .paddr(paddr), .psel(psel), .penable(penable),
    .pprot(pprot), .pwrite(pwrite), .pwdata(pwdata),
    .pstrb(pstrb), .pready(pready), .prdata(prdata),
    .pslverr(pslverr)
  );

  axi_lite_apb_bridge #(.TIMEOUT_CYCLES(8)) dut8 (
    .clock(clock), .reset(reset),
    .awvalid(awvalid), .awready(t_awready),
    .awaddr(awaddr), .awprot(awprot),
    .wvalid(wvalid), .wready(t_wready),
    .wdata(wdata), .wstrb(wstrb),
    .bvalid(t_bvalid), .bready(bready), .bresp(t_bresp),
    .arvalid(arvalid), .arready(t_arready),
    .araddr(araddr), .arprot(arprot),
    .rvalid(t_rvalid), .rready(rready),
    .rdata(t_rdata), .rresp(t_rresp),
    .paddr(t_paddr), .psel(t_psel), .penable(t_penable),
    .pprot(t_pprot), .pwrite(t_pwrite), .pwdata(t_pwdata),
    .pstrb(t_pstrb), .pready(pready), .prdata(prdata),
    .pslverr(pslverr)
  );

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [2:0]  prot;
    logic [1:0]  resp;
  } exp_t;

  exp_t sb[$];
  int   grants[$];
  int   n_chk = 0;
  int   n_err = 0;
  int   apb_delay = 0;
  int   exp_acc = 1;
  int   slv_cnt = 0;
  int   acc_len = 0;
  logic force_pready = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #2;
  endtask

  // APB slave: pready after apb_delay wait states
  always @(posedge clock) begin
    #2;
    if (psel && penable) begin
      pready = force_pready || (slv_cnt == apb_delay);
      slv_cnt++;
    end else begin
      pready = force_pready;
      slv_cnt = 0;
    end
  end

  task automatic take(input logic wr, input logic [31:0] d,
                      input logic [1:0] r);
    exp_t e;
    if (sb.size() == 0) begin
      check("resp_unexpected", 32'd1, 32'd0);
      return;
    end
    e = sb.pop_front();
    check("resp_kind", 32'(wr), 32'(e.wr));
    check("resp_code", 32'(r), 32'(e.resp));
    if (!wr) check("rdata", d, e.data);
  endtask

  always @(negedge clock) begin
    if (reset) begin
      acc_len = 0;
    end else begin
      if (arready) grants.push_back(0);
      else if (awready && wready) grants.push_back(1);
      if (psel && penable) begin
        acc_len++;
        if (pready) begin
          if (sb.size() == 0) begin
            check("apb_unexpected", 32'd1, 32'd0);
          end else begin
            check("paddr", paddr, sb[0].addr);
            check("pwrite", 32'(pwrite), 32'(sb[0].wr));
            check("pwdata", pwdata, sb[0].wr ? sb[0].data : 32'h0);
            check("pstrb", 32'(pstrb), sb[0].wr ? 32'(sb[0].strb) : 32'h0);
            check("pprot", 32'(pprot), 32'(sb[0].prot));
          end
          if (exp_acc != 0) check("access_len", 32'(acc_len), 32'(exp_acc));
          acc_len = 0;
        end
      end else begin
        acc_len = 0;
      end
      if (bvalid && bready) take(1'b1, 32'h0, bresp);
      if (rvalid && rready) take(1'b0, rdata, rresp);
    end
  end

  task automatic wait_grant(input logic wr, output int n);
    n = 0;
    #1;
    while (!(wr ? (awready && wready) : arready) && n < 100) begin
      step();
      #1;
      n++;
    end
    check("grant_timeout", 32'(n < 100), 32'd1);
  endtask

  task automatic wait_drain();
    int n = 0;
    while (sb.size() != 0 && n < 200) begin
      step();
      n++;
    end
    check("drain_timeout", 32'(n < 200), 32'd1);
  endtask

  task automatic do_write(input logic [31:0] a, input logic [31:0] d,
                          input logic [3:0] s, input logic [2:0] p,
                          input int wdelay);
    int n;
    sb.push_back('{wr: 1'b1, addr: a, data: d, strb: s, prot: p,
                   resp: 2'b00});
    awaddr  = a;
    awprot  = p;
    wdata   = d;
    wstrb   = s;
    awvalid = 1'b1;
    wvalid  = (wdelay == 0);
    for (int i = 0; i < wdelay; i++) begin
      #1;
      check("no_awready", 32'(awready | wready), 32'd0);
      check("no_psel", 32'(psel), 32'd0);
      step();
    end
    wvalid = 1'b1;
    wait_grant(1'b1, n);
    if (wdelay != 0) check("grant_same_cycle", 32'(n), 32'd0);
    step();
    awvalid = 1'b0;
    wvalid  = 1'b0;
  endtask

  task automatic do_read(input logic [31:0] a, input logic [2:0] p,
                         input logic [31:0] d, input logic [1:0] r);
    int n;
    sb.push_back('{wr: 1'b0, addr: a, data: d, strb: 4'h0, prot: p,
                   resp: r});
    araddr  = a;
    arprot  = p;
    arvalid = 1'b1;
    wait_grant(1'b0, n);
    step();
    arvalid = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ctl"}, 32'({awready, wready, arready, bvalid, rvalid,
                              psel, penable, pwrite, bresp, rresp}), 32'd0);
    check({tag, "_rdata"}, rdata, 32'd0);
    check({tag, "_paddr"}, paddr, 32'd0);
    check({tag, "_pwdata"}, pwdata, 32'd0);
    check({tag, "_pstrb_pprot"}, 32'({pstrb, pprot}), 32'd0);
  endtask

  initial begin
    int n;
    int g;
    int k;
    repeat (3) step();
    #1;
    check_all_zero("reset");
    reset = 1'b0;
    step();

    // single write, zero wait states, exact cycle timing
    sb.push_back('{wr: 1'b1, addr: 32'h1000_0004, data: 32'hDEAD_BEEF,
                   strb: 4'hF, prot: 3'b000, resp: 2'b00});
    awaddr  = 32'h1000_0004;
    awprot  = 3'b000;
    wdata   = 32'hDEAD_BEEF;
    wstrb   = 4'hF;
    awvalid = 1'b1;
    wvalid  = 1'b1;
    wait_grant(1'b1, n);
    check("wr_grant_now", 32'(n), 32'd0);
    step();
    awvalid = 1'b0;
    wvalid  = 1'b0;
    #1;
    check("setup_ctl", 32'({psel, penable, pwrite}), 32'b101);
    check("setup_paddr", paddr, 32'h1000_0004);
    check("setup_pwdata", pwdata, 32'hDEAD_BEEF);
    step();
    #1;
    check("access_ctl", 32'({psel, penable}), 32'b11);
    step();
    #1;
    check("wr_lat3_bvalid", 32'(bvalid), 32'd1);
    check("wr_lat3_bresp", 32'(bresp), 32'd0);
    check("wr_idle_psel", 32'({psel, penable}), 32'd0);
    wait_drain();

    // all valids held: grants must alternate starting with read
    prdata = 32'hA5A5_0001;
    grants.delete();
    for (int i = 0; i < 2; i++) begin
      sb.push_back('{wr: 1'b0, addr: 32'h2000_0000, data: 32'hA5A5_0001,
                     strb: 4'h0, prot: 3'b001, resp: 2'b00});
      sb.push_back('{wr: 1'b1, addr: 32'h3000_0000, data: 32'hCAFE_0001,
                     strb: 4'h3, prot: 3'b010, resp: 2'b00});
    end
    araddr  = 32'h2000_0000;
    arprot  = 3'b001;
    awaddr  = 32'h3000_0000;
    awprot  = 3'b010;
    wdata   = 32'hCAFE_0001;
    wstrb   = 4'h3;
    arvalid = 1'b1;
    awvalid = 1'b1;
    wvalid  = 1'b1;
    g = 0;
    n = 0;
    #1;
    while (n < 100) begin
      if (arready || (awready && wready)) g++;
      if (g == 4) break;
      step();
      #1;
      n++;
    end
    check("arb_grants", 32'(g), 32'd4);
    step();
    arvalid = 1'b0;
    awvalid = 1'b0;
    wvalid  = 1'b0;
    wait_drain();
    check("arb_log_len", 32'(grants.size()), 32'd4);
    for (int i = 0; i < grants.size() && i < 4; i++)
      check("arb_order", 32'(grants[i]), 32'(i % 2));

    // read with 12 wait states
    apb_delay = 12;
    exp_acc   = 13;
    prdata    = 32'h1234_5678;
    do_read(32'h1000_0008, 3'b011, 32'h1234_5678, 2'b00);
    wait_drain();
    apb_delay = 0;
    exp_acc   = 1;

    // write with wvalid late by 5 cycles
    do_write(32'h4000_0010, 32'h0BAD_F00D, 4'b0101, 3'b010, 5);
    wait_drain();

    // slave error on read with rready stalled
    pslverr = 1'b1;
    rready  = 1'b0;
    prdata  = 32'h5555_AAAA;
    do_read(32'h5000_0000, 3'b100, 32'h5555_AAAA, 2'b10);
    n = 0;
    #1;
    while (!rvalid && n < 50) begin
      step();
      #1;
      n++;
    end
    check("rvalid_timeout", 32'(n < 50), 32'd1);
    for (int i = 0; i < 6; i++) begin
      check("stall_rvalid", 32'(rvalid), 32'd1);
      check("stall_rresp", 32'(rresp), 32'd2);
      check("stall_rdata", rdata, 32'h5555_AAAA);
      step();
      #1;
    end
    rready  = 1'b1;
    pslverr = 1'b0;
    wait_drain();

    // reset during ACCESS abandons the read
    apb_delay = 50;
    exp_acc   = 0;
    do_read(32'h6000_0000, 3'b000, 32'h0, 2'b00);
    n = 0;
    #1;
    while (!penable && n < 20) begin
      step();
      #1;
      n++;
    end
    check("penable_timeout", 32'(n < 20), 32'd1);
    reset = 1'b1;
    step();
    #1;
    check_all_zero("midreset");
    sb.delete();
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      #1;
      check("no_resp_after_rst", 32'({rvalid, bvalid, psel}), 32'd0);
    end

    // timeout on the 8-cycle instance; slave never answers
    apb_delay = 1000;
    do_write(32'h7000_0000, 32'h1111_2222, 4'hF, 3'b000, 0);
    k = 0;
    n = 0;
    #1;
    while (!t_bvalid && n < 100) begin
      if (t_psel && t_penable) k++;
      step();
      #1;
      n++;
    end
    check("to_bvalid_seen", 32'(t_bvalid), 32'd1);
    check("to_access_cycles", 32'(k), 32'd8);
    check("to_bresp", 32'(t_bresp), 32'd2);
    step();
    #1;
    check("to_done", 32'({t_bvalid, t_psel}), 32'd0);
    force_pready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      #1;
      check("stray_pready", 32'({t_bvalid, t_rvalid, t_psel}), 32'd0);
    end
    force_pready = 1'b0;
    apb_delay    = 0;
    wait_drain();

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule

// File: doc/axi_lite_apb_bridge.md
AXI_LITE_APB_BRIDGE -- requirements
Module: axi_lite_apb_bridge

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 1024, max ACCESS cycles before forced error; 0 disables the timeout.
REQ-002 SHALL have port clock  in  1  sole clock; all logic on its rising edge.
REQ-003 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-004 SHALL have ports awvalid in 1, awready out 1, awaddr in 32, awprot in 3  AXI4-Lite write-address channel.
REQ-005 SHALL have ports wvalid in 1, wready out 1, wdata in 32, wstrb in 4  AXI4-Lite write-data channel.
REQ-006 SHALL have ports bvalid out 1, bready in 1, bresp out 2  AXI4-Lite write-response channel.
REQ-007 SHALL have ports arvalid in 1, arready out 1, araddr in 32, arprot in 3  AXI4-Lite read-address channel.
REQ-008 SHALL have ports rvalid out 1, rready in 1, rdata out 32, rresp out 2  AXI4-Lite read-data channel.
REQ-009 SHALL have APB master ports paddr out 32, psel out 1, penable out 1, pprot out 3, pwrite out 1, pwdata out 32, pstrb out 4, pready in 1, prdata in 32, pslverr in 1.

Function
REQ-010 SHALL implement FSM states IDLE, SETUP, ACCESS, WRESP, RRESP; one transfer in flight at a time.
REQ-011 In IDLE, a write is eligible only when awvalid and wvalid are both high; a read is eligible when arvalid is high.
REQ-012 Arbitration SHALL alternate: if both eligible, grant the type not granted last; after reset, read wins first.
REQ-013 Grant SHALL pulse awready and wready together (write) or arready (read) for exactly one cycle, capture addr/prot/data/strb in registers, and go to SETUP.
REQ-014 awready, wready, arready SHALL be 0 in every state except the IDLE grant cycle.
REQ-015 SETUP: psel=1, penable=0, APB outputs driven from captured registers; unconditionally to ACCESS next cycle.
REQ-016 ACCESS: psel=1, penable=1, outputs stable; stay until pready=1 sampled high.
REQ-017 On pready=1 in ACCESS: capture prdata (read) and pslverr; go to WRESP (write) or RRESP (read); psel and penable SHALL be 0 in the next cycle.
REQ-018 Timeout: an ACCESS cycle counter SHALL count from 0; when it reaches TIMEOUT_CYCLES-1 without pready, leave ACCESS as if pready=1 with pslverr=1 and rdata=32'h0.
REQ-019 pready, prdata, pslverr SHALL be ignored outside ACCESS.
REQ-020 pwdata and pstrb SHALL be 0 for reads; pwrite=1 only for writes.
REQ-021 WRESP: bvalid=1, bresp = 2'b10 if error else 2'b00; hold until bready=1, then IDLE.
REQ-022 RRESP: rvalid=1, rdata=captured data, rresp as for bresp; hold until rready=1, then IDLE.
REQ-023 Minimum latency grant-to-response-valid SHALL be 3 cycles (grant T, SETUP T+1, ACCESS T+2 with pready, response valid T+3).
REQ-024 A new grant SHALL not occur in the cycle a response handshakes; earliest next grant is the following IDLE cycle.
REQ-025 Whenever psel=0, paddr, pwrite, pprot SHALL hold their last values; penable SHALL be 0.

Reset
REQ-026 Synchronous reset SHALL force IDLE, arbitration pointer to "read next", timeout counter 0, and all outputs 0 (awready, wready, arready, bvalid, rvalid, psel, penable, pwrite, bresp, rresp, rdata, paddr, pwdata, pstrb, pprot).
REQ-027 Reset asserted mid-transfer SHALL abandon the transfer with no response issued; psel drops in the cycle after reset is sampled.

Verification
REQ-028 Write awaddr=0x1000_0004, wdata=0xDEADBEEF, wstrb=0xF, pready=1 in first ACCESS -> SETUP then ACCESS with paddr=0x1000_0004, pwrite=1, pwdata=0xDEADBEEF; bvalid with bresp=00 3 cycles after grant.
REQ-029 Read araddr=0x1000_0008, pready delayed 12 cycles, prdata=0x1234_5678 -> psel/penable held 12 extra cycles; rvalid with rdata=0x1234_5678, rresp=00.
REQ-030 arvalid, awvalid, wvalid held high continuously for 4 transfers -> granted order read, write, read, write.
REQ-031 awvalid=1, wvalid=0 for 5 cycles -> no awready, no APB activity; wvalid raised -> grant same cycle.
REQ-032 TIMEOUT_CYCLES=8, pready held 0 -> exactly 8 ACCESS cycles, then bvalid with bresp=10; later stray pready ignored.
REQ-033 pslverr=1 on a read; rready held 0 for 6 cycles -> rvalid, rresp=10 stable for 6 cycles; reset asserted during an ACCESS -> all outputs 0 next cycle, no rvalid.
